// File: rtl/rgb_to_hsv_if.sv
//------------------------------------------------------------------------------
// Module   : rgb_to_hsv_if
// Purpose  : Pixel-in / HSV-out handshake bundle for rgb_to_hsv.
// Signals  : in_valid/in_ready/rgb   - RGB565 pixel request channel
//            out_valid/out_ready/h/s/v - 8-bit HSV result channel
// Modports : master - the pixel producer / result consumer
//            slave  - the converter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rgb_to_hsv_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rgb;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  h;
  logic [7:0]  s;
  logic [7:0]  v;

  modport master (
    output in_valid, rgb, out_ready,
    input  in_ready, out_valid, h, s, v
  );

  modport slave (
    input  in_valid, rgb, out_ready,
    output in_ready, out_valid, h, s, v
  );
endinterface

`default_nettype wire

// File: rtl/rgb_to_hsv.sv
//------------------------------------------------------------------------------
// Module   : rgb_to_hsv
// Purpose  : Converts one RGB565 pixel into 8-bit hue/saturation/value using a
//            single shared 16/8 restoring divider (s first, then h). Hue uses
//            six sectors of SECTOR counts over 0..255.
// Ports    : clk   - system clock
//            reset - synchronous active-high reset
//            bus   - rgb_to_hsv_if.slave (in_valid/in_ready/rgb,
//                    out_valid/out_ready/h/s/v)
// Latency  : accept on edge k, out_valid from edge k+34.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rgb_to_hsv #(
  parameter int unsigned SECTOR  = 43,
  parameter int unsigned H_OFF_G = 85,
  parameter int unsigned H_OFF_B = 171
) (
  input wire          clk,
  input wire          reset,
  rgb_to_hsv_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    DIV_S = 3'd2,
    DIV_H = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] c_SEL_R = 2'd0;
  localparam logic [1:0] c_SEL_G = 2'd1;
  localparam logic [1:0] c_SEL_B = 2'd2;

  // 16 divider iterations use counts 0..15; DIV_S spends count 16 storing s
  // and reloading the divider for h.
  localparam logic [4:0] c_LAST_ITER = 5'd15;
  localparam logic [4:0] c_S_STORE   = 5'd16;

  state_t r_state;
  state_t w_state_nx;

  logic [15:0] r_rgb;
  logic [7:0]  r_vmax;
  logic [7:0]  r_delta;
  logic        r_neg;
  logic [15:0] r_hnum;
  logic [7:0]  r_hbase;
  logic [7:0]  r_sq;
  logic [7:0]  r_rem;
  logic [15:0] r_quo;
  logic [7:0]  r_div;
  logic [4:0]  r_cnt;
  logic [7:0]  r_h;
  logic [7:0]  r_s;
  logic [7:0]  r_v;

  // ---------------------------------------------------------------------------
  // Channel expansion and derived quantities from the latched pixel
  // ---------------------------------------------------------------------------
  logic [7:0]  w_r8;
  logic [7:0]  w_g8;
  logic [7:0]  w_b8;
  logic [1:0]  w_sel;
  logic [7:0]  w_max;
  logic [7:0]  w_min;
  logic [7:0]  w_delta;
  logic [8:0]  w_diff;
  logic        w_neg;
  logic [7:0]  w_absdiff;
  logic [7:0]  w_hbase;
  logic [15:0] w_hnum;
  logic [15:0] w_snum;

  assign w_r8 = {r_rgb[15:11], r_rgb[15:13]};
  assign w_g8 = {r_rgb[10:5],  r_rgb[10:9]};
  assign w_b8 = {r_rgb[4:0],   r_rgb[4:2]};

  always_comb begin
    w_sel   = c_SEL_R;
    w_max   = w_r8;
    w_diff  = {1'b0, w_g8} - {1'b0, w_b8};
    w_hbase = 8'd0;
    // Ties resolve to r first, then g.
    if ((w_r8 >= w_g8) && (w_r8 >= w_b8)) begin
      w_sel   = c_SEL_R;
      w_max   = w_r8;
      w_diff  = {1'b0, w_g8} - {1'b0, w_b8};
      w_hbase = 8'd0;
    end else if (w_g8 >= w_b8) begin
      w_sel   = c_SEL_G;
      w_max   = w_g8;
      w_diff  = {1'b0, w_b8} - {1'b0, w_r8};
      w_hbase = 8'(H_OFF_G);
    end else begin
      w_sel   = c_SEL_B;
      w_max   = w_b8;
      w_diff  = {1'b0, w_r8} - {1'b0, w_g8};
      w_hbase = 8'(H_OFF_B);
    end
  end

  always_comb begin
    w_min = w_r8;
    if (w_g8 < w_min) w_min = w_g8;
    if (w_b8 < w_min) w_min = w_b8;
  end

  assign w_delta   = w_max - w_min;
  // |diff| <= 255, so the 9-bit two's complement sign bit is bit 8.
  assign w_neg     = w_diff[8];
  assign w_absdiff = w_neg ? 8'(9'd0 - w_diff) : w_diff[7:0];
  assign w_hnum    = 16'(SECTOR) * {8'd0, w_absdiff};
  // 255*delta computed as (delta << 8) - delta.
  assign w_snum    = {w_delta, 8'd0} - {8'd0, w_delta};

  // ---------------------------------------------------------------------------
  // Restoring divider step: dividend shifts out of r_quo MSB-first while the
  // quotient bits shift in at the LSB.
  // ---------------------------------------------------------------------------
  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_rem_nx;
  logic [15:0] w_quo_nx;

  assign w_shift  = {r_rem, r_quo[15]};
  assign w_ge     = (w_shift >= {1'b0, r_div});
  assign w_rem_nx = w_ge ? 8'(w_shift - {1'b0, r_div}) : w_shift[7:0];
  assign w_quo_nx = {r_quo[14:0], w_ge};

  // A zero divisor yields an all-ones quotient; both results force it to 0.
  logic [7:0] w_s_res;
  logic [7:0] w_hq;
  logic [7:0] w_hoff;
  logic [7:0] w_h_res;

  assign w_s_res = (r_div == 8'd0) ? 8'd0 : r_quo[7:0];
  assign w_hq    = (r_div == 8'd0) ? 8'd0 : w_quo_nx[7:0];
  assign w_hoff  = r_neg ? (8'd0 - w_hq) : w_hq;
  assign w_h_res = (r_delta == 8'd0) ? 8'd0 : (r_hbase + w_hoff);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nx = PREP;
      PREP:    w_state_nx = DIV_S;
      DIV_S:   if (r_cnt == c_S_STORE) w_state_nx = DIV_H;
      DIV_H:   if (r_cnt == c_LAST_ITER) w_state_nx = DONE;
      DONE:    if (bus.out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.h         = r_h;
  assign bus.s         = r_s;
  assign bus.v         = r_v;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb   <= 16'd0;
      r_vmax  <= 8'd0;
      r_delta <= 8'd0;
      r_neg   <= 1'b0;
      r_hnum  <= 16'd0;
      r_hbase <= 8'd0;
      r_sq    <= 8'd0;
      r_rem   <= 8'd0;
      r_quo   <= 16'd0;
      r_div   <= 8'd0;
      r_cnt   <= 5'd0;
      r_h     <= 8'd0;
      r_s     <= 8'd0;
      r_v     <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) r_rgb <= bus.rgb;
        end
        PREP: begin
          r_vmax  <= w_max;
          r_delta <= w_delta;
          r_neg   <= w_neg;
          r_hnum  <= w_hnum;
          r_hbase <= w_hbase;
          r_rem   <= 8'd0;
          r_quo   <= w_snum;
          r_div   <= w_max;
          r_cnt   <= 5'd0;
        end
        DIV_S: begin
          if (r_cnt == c_S_STORE) begin
            r_sq  <= w_s_res;
            r_rem <= 8'd0;
            r_quo <= r_hnum;
            r_div <= r_delta;
            r_cnt <= 5'd0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        DIV_H: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 5'd1;
          // Final iteration: publish all three results together.
          if (r_cnt == c_LAST_ITER) begin
            r_h <= w_h_res;
            r_s <= r_sq;
            r_v <= r_vmax;
          end
        end
        default: ;
      endcase
    end
  end

  // Selector value is only informative; keep it observable for debug.
  logic w_sel_unused;
  assign w_sel_unused = ^w_sel;

endmodule

`default_nettype wire

// File: tb/tb_rgb_to_hsv.sv
//------------------------------------------------------------------------------
// Module   : tb_rgb_to_hsv
// Purpose  : Self-checking bench for rgb_to_hsv: directed pixels, random
//            pixels against an arithmetic HSV model, backpressure,
//            ignore-while-busy and mid-conversion reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rgb_to_hsv;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  rgb_to_hsv_if bus ();

  rgb_to_hsv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: HSV straight from the arithmetic definition.
  function automatic void model(input logic [15:0] px,
                                output int eh, output int es, output int ev);
    int r, g, b, mx, mn, dl, diff, base, term;
    r  = px[15:11] * 8 + px[15:13];
    g  = px[10:5] * 4 + px[10:9];
    b  = px[4:0] * 8 + px[4:2];
    mx = (r > g) ? r : g;  mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g;  mn = (mn < b) ? mn : b;
    dl = mx - mn;
    ev = mx;
    es = (mx == 0) ? 0 : (255 * dl) / mx;
    if (dl == 0) begin
      eh = 0;
    end else begin
      if (r == mx)      begin diff = g - b; base = 0;   end
      else if (g == mx) begin diff = b - r; base = 85;  end
      else              begin diff = r - g; base = 171; end
      term = (43 * ((diff < 0) ? -diff : diff)) / dl;
      eh = (base + ((diff < 0) ? -term : term)) & 255;
    end
  endfunction

  // Convert one pixel: checks latency, values, hold under backpressure and
  // handshake release. pulse_busy injects an in_valid pulse during DIV_H.
  task automatic run_pixel(input logic [15:0] px, input int eh, input int es,
                           input int ev, input int bp, input bit pulse_busy);
    int n;
    int seen;
    logic [7:0] hh, ss, vv;
    @(negedge clk);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.rgb       = px;
    bus.out_ready = (bp == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rgb      = 16'($urandom);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (pulse_busy && n == 25) begin
        bus.in_valid = 1'b1;
        bus.rgb      = 16'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("latency", n, 34);
    chk("h", int'(bus.h), eh);
    chk("s", int'(bus.s), es);
    chk("v", int'(bus.v), ev);
    hh = bus.h; ss = bus.s; vv = bus.v;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_hsv", int'({bus.h, bus.s, bus.v}), int'({hh, ss, vv}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
    if (pulse_busy) begin
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("no_extra_result", seen, 0);
    end
  endtask

  logic [15:0] dir_px [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                              16'h0000, 16'hF81F, 16'h8400, 16'h8410};
  int dir_h [8] = '{0,   85,  171, 0,   0, 213, 42,  213};
  int dir_s [8] = '{255, 255, 255, 0,   0, 255, 255, 3};
  int dir_v [8] = '{255, 255, 255, 255, 0, 255, 132, 132};

  initial begin
    int eh, es, ev;
    logic [15:0] px;
    checks   = 0;
    failures = 0;
    bus.in_valid  = 1'b0;
    bus.rgb       = 16'd0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_hsv", int'({bus.h, bus.s, bus.v}), 0);

    // Directed pixels with hand-derived expectations.
    for (int i = 0; i < 8; i++) begin
      run_pixel(dir_px[i], dir_h[i], dir_s[i], dir_v[i], 0, 1'b0);
    end

    // Backpressure for 10 cycles and an ignored in_valid pulse while busy.
    run_pixel(16'h8400, 42, 255, 132, 10, 1'b1);

    // Random pixels against the model, random short backpressure.
    for (int i = 0; i < 20; i++) begin
      px = 16'($urandom);
      model(px, eh, es, ev);
      run_pixel(px, eh, es, ev, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during DIV_S aborts the conversion.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.rgb      = 16'h001F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_hsv", int'({bus.h, bus.s, bus.v}), 0);
    run_pixel(16'h07E0, 85, 255, 255, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
